// File: rtl/regfile_wb_arbiter.sv
// Write-port front end for RegFile: merges pipeline writeback with buffered long-latency results
// and tracks a busy scoreboard. Define WB_BYPASS_EN to forward the in-flight write to decode.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_wa,
  input  logic [DATA_W-1:0] pipe_wd,
  input  logic              lu_issue,
  input  logic [ADDR_W-1:0] lu_issue_rd,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              byp1_valid,
  output logic              byp2_valid,
  output logic [DATA_W-1:0] byp1_data,
  output logic [DATA_W-1:0] byp2_data
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]  rf_wd_q, rf_wd_d;

  logic pipe_eff, push, pop;

  assign lu_ready = (count_q < DepthCnt);
  assign pipe_eff = pipe_we && (pipe_wa != '0);
  // x0 results are acknowledged but never buffered.
  assign push     = lu_valid && lu_ready && (lu_rd != '0);
  assign pop      = !pipe_eff && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear before set so a same-edge issue to the popped register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    if (lu_issue && (lu_issue_rd != '0)) busy_d[lu_issue_rd] = 1'b1;
  end

  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    if (pipe_eff) begin
      rf_we_d = 1'b1;
      rf_wa_d = pipe_wa;
      rf_wd_d = pipe_wd;
    end else if (pop) begin
      rf_we_d = 1'b1;
      rf_wa_d = fifo_rd_q[rd_ptr_q];
      rf_wd_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      busy_q  <= busy_d;
      rf_we_q <= rf_we_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= lu_rd;
      fifo_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_wa   = rf_wa_q;
  assign rf_wd   = rf_wd_q;
  assign hazard1 = busy_q[ra1] && (ra1 != '0);
  assign hazard2 = busy_q[ra2] && (ra2 != '0);

`ifdef WB_BYPASS_EN
  assign byp1_valid = rf_we_q && (rf_wa_q == ra1) && (ra1 != '0);
  assign byp2_valid = rf_we_q && (rf_wa_q == ra2) && (ra2 != '0);
  assign byp1_data  = rf_wd_q;
  assign byp2_data  = rf_wd_q;
`else
  assign byp1_valid = 1'b0;
  assign byp2_valid = 1'b0;
  assign byp1_data  = '0;
  assign byp2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus hand sequences for
// buffering order and asynchronous reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we, lu_issue, lu_valid, lu_ready;
  logic [4:0]  pipe_wa, lu_issue_rd, lu_rd, ra1, ra2, rf_wa;
  logic [31:0] pipe_wd, lu_data, rf_wd, byp1_data, byp2_data;
  logic        hazard1, hazard2, rf_we, byp1_valid, byp2_valid;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .byp1_valid(byp1_valid), .byp2_valid(byp2_valid),
    .byp1_data(byp1_data), .byp2_data(byp2_data)
  );

  typedef struct {
    logic        pwe;  logic [4:0] pwa; logic [31:0] pwd;
    logic        iss;  logic [4:0] ird;
    logic        lv;   logic [4:0] lrd; logic [31:0] ldat;
    logic [4:0]  ra1;  logic [4:0] ra2;
    logic        ewe;  logic [4:0] ewa; logic [31:0] ewd;
    logic        erdy; logic eh1; logic eh2;
  } vec_t;

  vec_t vecs [18];
  logic [36:0] wr_log [$];
  logic [36:0] wr_exp [5];

  // Every registered-file write is recorded once per cycle, away from the active edge.
  always @(negedge clk) if (rf_we) wr_log.push_back({rf_wa, rf_wd});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0; lu_issue = 0; lu_issue_rd = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0; ra1 = 0; ra2 = 0;
  endtask

  task automatic chk_byp(input string tag, input logic ewe, input logic [4:0] ewa,
                         input logic [31:0] ewd, input logic [4:0] r1, input logic [4:0] r2);
    logic v1, v2;
`ifdef WB_BYPASS_EN
    v1 = ewe && (ewa == r1) && (r1 != 0);
    v2 = ewe && (ewa == r2) && (r2 != 0);
    chk({tag, ".byp1_valid"}, 32'(byp1_valid), 32'(v1));
    chk({tag, ".byp2_valid"}, 32'(byp2_valid), 32'(v2));
    if (v1) chk({tag, ".byp1_data"}, byp1_data, ewd);
    if (v2) chk({tag, ".byp2_data"}, byp2_data, ewd);
`else
    v1 = 1'b0;
    v2 = 1'b0;
    chk({tag, ".byp1_valid"}, 32'(byp1_valid), 32'(v1));
    chk({tag, ".byp2_valid"}, 32'(byp2_valid), 32'(v2));
    chk({tag, ".byp1_data"}, byp1_data, 32'h0);
    chk({tag, ".byp2_data"}, byp2_data, 32'h0);
`endif
  endtask

  initial begin
    // pwe pwa pwd | iss ird | lv lrd ldat | ra1 ra2 | ewe ewa ewd | rdy h1 h2
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[1]  = '{1, 2, 32'h10838234, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 1, 2, 32'h10838234, 1, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[4]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        0, 0, 1, 0, 32'h12345678, 0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[8]  = '{0, 0, 32'h0,        1, 5, 0, 0, 32'h0,        5, 0, 0, 0, 32'h0,        1, 0, 0};
    vecs[9]  = '{0, 0, 32'h0,        0, 0, 1, 5, 32'hFEEDABBA, 5, 0, 0, 0, 32'h0,        1, 1, 0};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        5, 0, 0, 0, 32'h0,        1, 1, 0};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        5, 0, 1, 5, 32'hFEEDABBA, 1, 0, 0};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        5, 5, 0, 0, 32'h0,        1, 0, 0};
    vecs[13] = '{0, 0, 32'h0,        1, 6, 0, 0, 32'h0,        0, 6, 0, 0, 32'h0,        1, 0, 0};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 1, 6, 32'hA5A5A5A5, 0, 6, 0, 0, 32'h0,        1, 0, 1};
    vecs[15] = '{0, 0, 32'h0,        1, 6, 0, 0, 32'h0,        0, 6, 0, 0, 32'h0,        1, 0, 1};
    vecs[16] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        6, 6, 1, 6, 32'hA5A5A5A5, 1, 1, 1};
    vecs[17] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        6, 6, 0, 0, 32'h0,        1, 1, 1};

    wr_exp[0] = {5'd8,  32'h80};
    wr_exp[1] = {5'd9,  32'h90};
    wr_exp[2] = {5'd10, 32'hA0};
    wr_exp[3] = {5'd6,  32'h66};
    wr_exp[4] = {5'd7,  32'h77};

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("rst.rf_we", 32'(rf_we), 32'h0);
    chk("rst.rf_wa", 32'(rf_wa), 32'h0);
    chk("rst.rf_wd", rf_wd, 32'h0);
    chk("rst.lu_ready", 32'(lu_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle vectors: drive on negedge, compare 1 time unit later
    for (int i = 0; i < 18; i++) begin
      string tag;
      @(negedge clk);
      pipe_we = vecs[i].pwe; pipe_wa = vecs[i].pwa; pipe_wd = vecs[i].pwd;
      lu_issue = vecs[i].iss; lu_issue_rd = vecs[i].ird;
      lu_valid = vecs[i].lv; lu_rd = vecs[i].lrd; lu_data = vecs[i].ldat;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, ".rf_we"}, 32'(rf_we), 32'(vecs[i].ewe));
      if (vecs[i].ewe) begin
        chk({tag, ".rf_wa"}, 32'(rf_wa), 32'(vecs[i].ewa));
        chk({tag, ".rf_wd"}, rf_wd, vecs[i].ewd);
      end
      chk({tag, ".lu_ready"}, 32'(lu_ready), 32'(vecs[i].erdy));
      chk({tag, ".hazard1"}, 32'(hazard1), 32'(vecs[i].eh1));
      chk({tag, ".hazard2"}, 32'(hazard2), 32'(vecs[i].eh2));
      chk_byp(tag, vecs[i].ewe, vecs[i].ewa, vecs[i].ewd, vecs[i].ra1, vecs[i].ra2);
    end

    // Two buffered results behind three pipeline writes: ordering and backpressure
    @(negedge clk);
    idle_inputs();
    wr_log.delete();
    #1;
    @(negedge clk);
    pipe_we = 1; pipe_wa = 8; pipe_wd = 32'h80; lu_valid = 1; lu_rd = 6; lu_data = 32'h66;
    #1 chk("ord.ready_a", 32'(lu_ready), 32'h1);
    @(negedge clk);
    pipe_wa = 9; pipe_wd = 32'h90; lu_rd = 7; lu_data = 32'h77;
    #1 chk("ord.ready_b", 32'(lu_ready), 32'h1);
    @(negedge clk);
    pipe_wa = 10; pipe_wd = 32'hA0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    #1 chk("ord.ready_full", 32'(lu_ready), 32'h0);
    @(negedge clk);
    idle_inputs();
    #1 chk("ord.ready_still_full", 32'(lu_ready), 32'h0);
    @(negedge clk);
    ra1 = 6; ra2 = 7;
    #1 chk("ord.ready_after_pop", 32'(lu_ready), 32'h1);
    chk("ord.hz_rd6_cleared", 32'(hazard1), 32'h0);
    chk("ord.hz_rd7", 32'(hazard2), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("ord.write_count", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_log.size()) begin
        chk($sformatf("ord.wa%0d", i), 32'(wr_log[i][36:32]), 32'(wr_exp[i][36:32]));
        chk($sformatf("ord.wd%0d", i), wr_log[i][31:0], wr_exp[i][31:0]);
      end
    end

    // Fill the FIFO behind a stream of pipeline writes, then reset mid-cycle
    @(negedge clk);
    pipe_we = 1; pipe_wa = 13; pipe_wd = 32'hD0;
    lu_issue = 1; lu_issue_rd = 11; lu_valid = 1; lu_rd = 11; lu_data = 32'hB1;
    @(negedge clk);
    lu_issue_rd = 12; lu_rd = 12; lu_data = 32'hC2;
    @(negedge clk);
    lu_issue = 0; lu_issue_rd = 0; lu_valid = 0; lu_rd = 0; lu_data = 0;
    ra1 = 11; ra2 = 12;
    #1;
    chk("rstmid.pre_hz1", 32'(hazard1), 32'h1);
    chk("rstmid.pre_hz2", 32'(hazard2), 32'h1);
    chk("rstmid.pre_ready", 32'(lu_ready), 32'h0);
    chk("rstmid.pre_we", 32'(rf_we), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.rf_we", 32'(rf_we), 32'h0);
    chk("rstmid.rf_wa", 32'(rf_wa), 32'h0);
    chk("rstmid.rf_wd", rf_wd, 32'h0);
    chk("rstmid.hz1", 32'(hazard1), 32'h0);
    chk("rstmid.hz2", 32'(hazard2), 32'h0);
    chk("rstmid.ready", 32'(lu_ready), 32'h1);
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_log.delete();
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid.no_stale_writes", 32'(wr_log.size()), 32'd0);
    chk("rstmid.post_ready", 32'(lu_ready), 32'h1);
    chk("rstmid.post_hz1", 32'(hazard1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port front end for RegFile. It merges two writeback sources into RegFile's single write port (we/wa/wd):
- the in-order pipeline writeback, which is always accepted;
- a valid/ready result stream from the long-latency unit (mul/div), which is buffered.
It also keeps a busy scoreboard of registers awaiting long-latency results, and reports read hazards to decode.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
pipe_we  input  1  pipeline writeback enable
pipe_wa  input  ADDR_W  pipeline writeback register
pipe_wd  input  DATA_W  pipeline writeback data
lu_issue  input  1  long-latency op issued this cycle
lu_issue_rd  input  ADDR_W  destination register of the issued op
lu_valid  input  1  long-latency result valid
lu_ready  output  1  arbiter can accept a result
lu_rd  input  ADDR_W  result destination register
lu_data  input  DATA_W  result data
ra1, ra2  input  ADDR_W  decode read addresses
hazard1, hazard2  output  1  ra1/ra2 register is busy
rf_we  output  1  to RegFile we
rf_wa  output  ADDR_W  to RegFile wa
rf_wd  output  DATA_W  to RegFile wd
byp1_valid, byp2_valid  output  1  bypass hit (see Optional Feature)
byp1_data, byp2_data  output  DATA_W  bypass data

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_wa=0, rf_wd=0.
  - FIFO emptied; count=0, so lu_ready=1.
  - busy[31:0]=0, so hazard1/2=0.
  - Reset mid-operation discards all buffered results.
- rf_we, rf_wa and rf_wd are registered.
  - Pipeline write latency is 1 cycle: pipe_we at edge N gives rf_we=1 in the cycle after edge N.
- x0 writes:
  - pipe_we with pipe_wa=0 is treated as no write; rf_we stays 0.
  - An lu handshake with lu_rd=0 is consumed (lu_ready honoured) and discarded; it never enters the FIFO.
- lu handshake:
  - A transfer occurs on an edge with lu_valid && lu_ready.
  - lu_ready = (count < FIFO_DEPTH). It depends on count only, not on a same-cycle pop.
  - lu_rd and lu_data must hold while lu_valid=1 && lu_ready=0.
- Arbitration, each cycle:
  - If the pipeline write is effective, drive the next rf_* from the pipe.
  - Else, if the FIFO is non-empty, pop the head into rf_*.
  - Else rf_we=0.
  - The pipeline always wins. FIFO order is preserved.
  - Push and pop on the same edge are allowed; count is unchanged.
- Minimum lu latency: accept at edge N, pop at edge N+1, rf_we=1 in the cycle after N+1.
- Scoreboard:
  - lu_issue with lu_issue_rd!=0 sets busy[lu_issue_rd] at the edge.
  - busy[r] clears on the edge where a FIFO entry with rd=r is popped.
  - Same-edge set and clear on the same r: set wins.
  - Pipeline writes never touch busy.
- Hazards:
  - hazardK = busy[raK] && raK!=0, combinational.
  - hazardK deasserts in the same cycle that rf_we writes r, so a RegFile read in the following cycle returns the new value.
- Count wrap: FIFO pointers wrap modulo FIFO_DEPTH. count never exceeds FIFO_DEPTH and never goes below 0.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined:
  - bypK_valid = rf_we && rf_wa==raK && raK!=0.
  - bypK_data = rf_wd.
  - This forwards the in-flight write for RegFile implementations without write-through.
- When undefined: byp*_valid=0 and byp*_data=0. No extra logic.

Test Plan:
1. Reset release, then pipe_we=1 wa=2 wd=0x10838234 for one cycle -> next cycle rf_we=1, rf_wa=2, rf_wd=0x10838234; following cycle rf_we=0.
2. pipe_we=1 wa=0 wd=0xFFFFFFFF -> rf_we remains 0. An lu result with rd=0 -> lu_ready=1, FIFO count stays 0.
3. lu_issue rd=5, ra1=5 -> hazard1=1 from the next cycle. Result rd=5 data=0xFEEDABBA accepted while idle -> rf_we=1, wa=5, wd=0xFEEDABBA two cycles after the accept edge; hazard1=0 in that cycle. With WB_BYPASS_EN: byp1_valid=1, byp1_data=0xFEEDABBA.
4. Two lu results (rd=6, then rd=7) while pipe writes x8, x9, x10 on consecutive cycles -> lu_ready=0 after the second accept; rf writes 8, 9, 10, 6, 7 in that order; lu_ready=1 after the first pop.
5. Same edge: pop of rd=6 and lu_issue rd=6 -> busy[6] stays 1, hazard on ra=6 persists.
6. FIFO holding 2 entries with busy bits set, rst_n pulsed low mid-cycle -> rf_we=0, hazards=0, lu_ready=1 immediately, before the next clock edge. No stale writes after release.
